// File: rtl/procyon_biu_wb_pkg.sv
// Shared procyon BIU constants: request function codes, length encodings
// (log2 of the byte count) and a helper that clamps a length to a full line.
package procyon_biu_wb_pkg;

    localparam int PCYN_BIU_FUNC_WIDTH = 1;
    localparam logic [PCYN_BIU_FUNC_WIDTH-1:0] PCYN_BIU_FUNC_READ  = 1'b0;
    localparam logic [PCYN_BIU_FUNC_WIDTH-1:0] PCYN_BIU_FUNC_WRITE = 1'b1;

    localparam int PCYN_BIU_LEN_WIDTH = 3;
    localparam logic [PCYN_BIU_LEN_WIDTH-1:0] PCYN_BIU_LEN_1B   = 3'd0;
    localparam logic [PCYN_BIU_LEN_WIDTH-1:0] PCYN_BIU_LEN_2B   = 3'd1;
    localparam logic [PCYN_BIU_LEN_WIDTH-1:0] PCYN_BIU_LEN_4B   = 3'd2;
    localparam logic [PCYN_BIU_LEN_WIDTH-1:0] PCYN_BIU_LEN_8B   = 3'd3;
    localparam logic [PCYN_BIU_LEN_WIDTH-1:0] PCYN_BIU_LEN_16B  = 3'd4;
    localparam logic [PCYN_BIU_LEN_WIDTH-1:0] PCYN_BIU_LEN_32B  = 3'd5;
    localparam logic [PCYN_BIU_LEN_WIDTH-1:0] PCYN_BIU_LEN_64B  = 3'd6;
    localparam logic [PCYN_BIU_LEN_WIDTH-1:0] PCYN_BIU_LEN_128B = 3'd7;

    // Lengths beyond a cache line are treated as a full line.
    function automatic logic [PCYN_BIU_LEN_WIDTH-1:0] pcyn_biu_clamp_len(
        input logic [PCYN_BIU_LEN_WIDTH-1:0] len,
        input int unsigned                   max_log2
    );
        if (32'(len) > max_log2) return PCYN_BIU_LEN_WIDTH'(max_log2);
        return len;
    endfunction

endpackage

// File: rtl/procyon_biu_wb_linebuf.sv
// Beat-indexed line buffer for the BIU.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (clears the buffer)
//   load       capture load_data and load the down-counter with load_cnt
//   step       one beat completed; fill stores wb_dat into the current slot
//   last       the current beat is the final one of the transfer
//   next_word  buffer slot following the current beat (next write beat)
//   fill_line  buffer contents with the current slot replaced by wb_dat
module procyon_biu_wb_linebuf #(
    parameter int LINE_WIDTH = 256,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [LINE_WIDTH-1:0] load_data,
    input  logic [IDX_W-1:0]      load_cnt,
    input  logic                  step,
    input  logic                  fill,
    input  logic [DATA_WIDTH-1:0] wb_dat,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] next_word,
    output logic [LINE_WIDTH-1:0] fill_line
);

    localparam int BEATS = LINE_WIDTH / DATA_WIDTH;

    logic [BEATS-1:0][DATA_WIDTH-1:0] line_q;
    logic [BEATS-1:0][DATA_WIDTH-1:0] filled;
    logic [IDX_W-1:0]                 cnt_q;
    logic [IDX_W-1:0]                 idx_q;
    logic [IDX_W-1:0]                 idx_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
        end else if (load) begin
            line_q <= load_data;
            cnt_q  <= load_cnt;
            idx_q  <= '0;
        end else if (step) begin
            if (fill) line_q[idx_q] <= wb_dat;
            cnt_q <= cnt_q - 1'b1;
            idx_q <= idx_next;
        end
    end

    assign idx_next  = idx_q + 1'b1;
    assign last      = (cnt_q == '0);
    assign next_word = line_q[idx_next];

    // The final read beat lands in the same edge as completion, so the
    // completed line is assembled from the buffer plus the live bus data.
    always_comb begin
        filled        = line_q;
        filled[idx_q] = wb_dat;
    end

    assign fill_line = filled;

endmodule

// File: rtl/procyon_biu_wb.sv
// BIU responder: executes one CCU request at a time as a Wishbone B4
// classic block cycle and returns a one-cycle done pulse with read data.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   i_biu_en/func/len/addr/data  CCU request (held until o_biu_done)
//   o_biu_done, o_biu_data       completion pulse, right-justified read data
//   o_wb_*                       Wishbone master outputs (all registered)
//   i_wb_ack, i_wb_dat           Wishbone beat acknowledge and read data
module procyon_biu_wb
    import procyon_biu_wb_pkg::*;
#(
    parameter int OPTN_ADDR_WIDTH    = 32,
    parameter int OPTN_CCU_LINE_SIZE = 32,
    parameter int OPTN_WB_DATA_WIDTH = 16,
    parameter int OPTN_WB_ADDR_WIDTH = 32,
    parameter int CCU_LINE_WIDTH     = OPTN_CCU_LINE_SIZE * 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_biu_en,
    input  logic [PCYN_BIU_FUNC_WIDTH-1:0] i_biu_func,
    input  logic [PCYN_BIU_LEN_WIDTH-1:0]  i_biu_len,
    input  logic [OPTN_ADDR_WIDTH-1:0]     i_biu_addr,
    input  logic [CCU_LINE_WIDTH-1:0]      i_biu_data,
    output logic                           o_biu_done,
    output logic [CCU_LINE_WIDTH-1:0]      o_biu_data,
    output logic                           o_wb_cyc,
    output logic                           o_wb_stb,
    output logic                           o_wb_we,
    output logic [OPTN_WB_DATA_WIDTH/8-1:0] o_wb_sel,
    output logic [OPTN_WB_ADDR_WIDTH-1:0]  o_wb_adr,
    output logic [OPTN_WB_DATA_WIDTH-1:0]  o_wb_dat,
    input  logic                           i_wb_ack,
    input  logic [OPTN_WB_DATA_WIDTH-1:0]  i_wb_dat
);

    localparam int unsigned WB_BYTES  = OPTN_WB_DATA_WIDTH / 8;
    localparam int unsigned WB_LOG2   = $clog2(WB_BYTES);
    localparam int unsigned LINE_LOG2 = $clog2(OPTN_CCU_LINE_SIZE);
    localparam int unsigned MAX_BEATS = OPTN_CCU_LINE_SIZE / WB_BYTES;
    localparam int unsigned IDX_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int unsigned LANE_W    = (WB_LOG2 > 0) ? WB_LOG2 : 1;
    localparam int unsigned LANE_MASK = WB_BYTES - 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_n;

    logic                          cyc_n, stb_n, we_n, done_n;
    logic [WB_BYTES-1:0]           sel_n;
    logic [OPTN_WB_ADDR_WIDTH-1:0] adr_n;
    logic [OPTN_WB_DATA_WIDTH-1:0] dat_n;
    logic [CCU_LINE_WIDTH-1:0]     data_n;

    logic [PCYN_BIU_LEN_WIDTH-1:0] req_len, len_q;
    logic [LANE_W-1:0]             req_lane, lane_q;
    logic                          req_sub, sub_q;
    int unsigned                   req_size, req_lane_i, size_q_i;
    logic [IDX_W-1:0]              req_cnt;

    logic                          load, step, last;
    logic [CCU_LINE_WIDTH-1:0]     load_data, fill_line, rd_sub;
    logic [OPTN_WB_DATA_WIDTH-1:0] next_word, rd_shift;

    // Request decode: clamped length, lane offset and beat count.
    always_comb begin
        req_len    = pcyn_biu_clamp_len(i_biu_len, LINE_LOG2);
        req_size   = 32'd1 << req_len;
        req_lane   = LANE_W'(i_biu_addr) & LANE_W'(LANE_MASK);
        req_lane_i = 32'(req_lane);
        req_sub    = (req_size < WB_BYTES);
        req_cnt    = req_sub ? '0
                   : IDX_W'((32'd1 << (32'(req_len) - WB_LOG2)) - 32'd1);
        load_data  = (i_biu_func == PCYN_BIU_FUNC_WRITE) ? i_biu_data : '0;
    end

    // Sub-bus read: bring the addressed lanes down to bit 0, zero the rest.
    always_comb begin
        rd_shift = i_wb_dat >> {lane_q, 3'b000};
        size_q_i = 32'd1 << len_q;
        rd_sub   = '0;
        for (int unsigned b = 0; b < WB_BYTES; b++) begin
            if (b < size_q_i) rd_sub[b*8 +: 8] = rd_shift[b*8 +: 8];
        end
    end

    always_comb begin
        state_n = state;
        cyc_n   = o_wb_cyc;
        stb_n   = o_wb_stb;
        we_n    = o_wb_we;
        sel_n   = o_wb_sel;
        adr_n   = o_wb_adr;
        dat_n   = o_wb_dat;
        data_n  = o_biu_data;
        done_n  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state)
            IDLE: begin
                if (i_biu_en) begin
                    load    = 1'b1;
                    state_n = BUSY;
                    cyc_n   = 1'b1;
                    stb_n   = 1'b1;
                    we_n    = (i_biu_func == PCYN_BIU_FUNC_WRITE);
                    adr_n   = OPTN_WB_ADDR_WIDTH'(i_biu_addr)
                            & ~OPTN_WB_ADDR_WIDTH'(LANE_MASK);
                    sel_n   = req_sub
                            ? WB_BYTES'(((32'd1 << req_size) - 32'd1) << req_lane_i)
                            : '1;
                    // Masking the byte index by the transfer size replicates
                    // sub-bus data across all lanes and reduces to a plain
                    // copy of the first bus word for multi-beat transfers.
                    for (int unsigned b = 0; b < WB_BYTES; b++) begin
                        dat_n[b*8 +: 8] = i_biu_data[(b & (req_size - 32'd1))*8 +: 8];
                    end
                end
            end
            BUSY: begin
                if (i_wb_ack) begin
                    step = 1'b1;
                    if (last) begin
                        state_n = DONE;
                        cyc_n   = 1'b0;
                        stb_n   = 1'b0;
                        done_n  = 1'b1;
                        if (!o_wb_we) data_n = sub_q ? rd_sub : fill_line;
                    end else begin
                        adr_n = o_wb_adr + OPTN_WB_ADDR_WIDTH'(WB_BYTES);
                        dat_n = next_word;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            o_wb_cyc   <= 1'b0;
            o_wb_stb   <= 1'b0;
            o_wb_we    <= 1'b0;
            o_wb_sel   <= '0;
            o_wb_adr   <= '0;
            o_wb_dat   <= '0;
            o_biu_done <= 1'b0;
            o_biu_data <= '0;
            len_q      <= '0;
            lane_q     <= '0;
            sub_q      <= 1'b0;
        end else begin
            state      <= state_n;
            o_wb_cyc   <= cyc_n;
            o_wb_stb   <= stb_n;
            o_wb_we    <= we_n;
            o_wb_sel   <= sel_n;
            o_wb_adr   <= adr_n;
            o_wb_dat   <= dat_n;
            o_biu_done <= done_n;
            o_biu_data <= data_n;
            if (load) begin
                len_q  <= req_len;
                lane_q <= req_lane;
                sub_q  <= req_sub;
            end
        end
    end

    procyon_biu_wb_linebuf #(
        .LINE_WIDTH (CCU_LINE_WIDTH),
        .DATA_WIDTH (OPTN_WB_DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_linebuf (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .load_cnt  (req_cnt),
        .step      (step),
        .fill      (!o_wb_we),
        .wb_dat    (i_wb_dat),
        .last      (last),
        .next_word (next_word),
        .fill_line (fill_line)
    );

endmodule

// File: tb/tb_procyon_biu_wb.sv
module tb_procyon_biu_wb;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         biu_en = 1'b0;
    logic [0:0]   biu_func = 1'b0;
    logic [2:0]   biu_len = '0;
    logic [31:0]  biu_addr = '0;
    logic [255:0] biu_data = '0;
    logic         biu_done;
    logic [255:0] biu_rdata;
    logic         wb_cyc, wb_stb, wb_we;
    logic [1:0]   wb_sel;
    logic [31:0]  wb_adr;
    logic [15:0]  wb_dat_o;
    logic         wb_ack = 1'b0;
    logic [15:0]  wb_dat_i = '0;

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    logic [7:0]   mem     [0:1023];
    logic [7:0]   ref_mem [0:1023];
    logic [255:0] last_rd = '0;

    always #5 clk = ~clk;

    procyon_biu_wb #(
        .OPTN_ADDR_WIDTH    (32),
        .OPTN_CCU_LINE_SIZE (32),
        .OPTN_WB_DATA_WIDTH (16),
        .OPTN_WB_ADDR_WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_biu_en   (biu_en),
        .i_biu_func (biu_func),
        .i_biu_len  (biu_len),
        .i_biu_addr (biu_addr),
        .i_biu_data (biu_data),
        .o_biu_done (biu_done),
        .o_biu_data (biu_rdata),
        .o_wb_cyc   (wb_cyc),
        .o_wb_stb   (wb_stb),
        .o_wb_we    (wb_we),
        .o_wb_sel   (wb_sel),
        .o_wb_adr   (wb_adr),
        .o_wb_dat   (wb_dat_o),
        .i_wb_ack   (wb_ack),
        .i_wb_dat   (wb_dat_i)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request through the DUT with a Wishbone responder inserting `waits`
    // wait cycles per beat. Expectations come from a byte-addressed reference
    // memory: a transfer covers bytes addr .. addr+size-1.
    task automatic run_txn(input logic wr, input int unsigned len, input int unsigned addr,
                           input logic [255:0] data, input int unsigned waits);
        int unsigned  lc, size, beats, base, beat, wcnt, exp_adr, a;
        logic [255:0] exp_rd, got_mem, exp_mem;
        logic [1:0]   exp_sel;
        bit           done_seen;
        lc    = (len > 5) ? 5 : len;
        size  = 1 << lc;
        beats = (size >= 2) ? size / 2 : 1;
        base  = addr & ~32'd1;
        exp_rd = '0;
        if (wr) begin
            for (int i = 0; i < int'(size); i++) ref_mem[addr + i] = data[8*i +: 8];
        end else begin
            for (int i = 0; i < int'(size); i++) exp_rd[8*i +: 8] = ref_mem[addr + i];
        end
        biu_en   = 1'b1;
        biu_func = wr;
        biu_len  = 3'(len);
        biu_addr = addr;
        biu_data = data;
        beat = 0;
        wcnt = 0;
        done_seen = 0;
        for (int unsigned it = 0; it < 600 && !done_seen; it++) begin
            @(negedge clk);
            if (biu_done) begin
                done_seen = 1;
                wb_ack = 1'b0;
                check("latency", it, beats * (waits + 1));
                check("beats_acked", beat, beats);
                check("cyc_after_done", {wb_cyc, wb_stb}, 2'b00);
                if (wr) begin
                    check("rdata_hold", biu_rdata, last_rd);
                end else begin
                    check("rdata", biu_rdata, exp_rd);
                    last_rd = exp_rd;
                end
            end else begin
                exp_adr = base + 2 * beat;
                for (int b = 0; b < 2; b++) begin
                    a = exp_adr + b;
                    exp_sel[b] = (a >= addr) && (a < addr + size);
                end
                check("cyc_stb_we", {wb_cyc, wb_stb, wb_we}, {1'b1, 1'b1, wr});
                check("adr", wb_adr, exp_adr);
                check("sel", wb_sel, exp_sel);
                if (wr) begin
                    for (int b = 0; b < 2; b++) begin
                        if (exp_sel[b])
                            check("wdat", wb_dat_o[8*b +: 8], data[8*(exp_adr + b - addr) +: 8]);
                    end
                end
                if (wcnt == waits) begin
                    wb_ack   = 1'b1;
                    wb_dat_i = {mem[(exp_adr + 1) & 1023], mem[exp_adr & 1023]};
                    if (wb_we) begin
                        for (int b = 0; b < 2; b++)
                            if (wb_sel[b]) mem[(wb_adr + b) & 1023] = wb_dat_o[8*b +: 8];
                    end
                    beat++;
                    wcnt = 0;
                end else begin
                    wb_ack   = 1'b0;
                    wb_dat_i = 16'($urandom);
                    wcnt++;
                end
            end
        end
        wb_ack = 1'b0;
        if (!done_seen) check("done_timeout", 0, 1);
        // Requestor still holds en during the cycle after done.
        @(negedge clk);
        check("done_single_pulse", biu_done, 1'b0);
        check("no_restart_from_done", wb_cyc, 1'b0);
        biu_en = 1'b0;
        @(negedge clk);
        check("idle_after_done", wb_cyc, 1'b0);
        if (wr) begin
            got_mem = '0;
            exp_mem = '0;
            for (int i = 0; i < int'(size); i++) begin
                got_mem[8*i +: 8] = mem[addr + i];
                exp_mem[8*i +: 8] = ref_mem[addr + i];
            end
            check("mem_write", got_mem, exp_mem);
        end
    endtask

    initial begin
        logic [255:0] d;
        int unsigned  len, size, addr;

        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o, biu_done, biu_rdata}, '0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", wb_cyc, 1'b0);

        // Line read, zero-wait
        run_txn(1'b0, 5, 32'h100, '0, 0);

        // Line write, two wait cycles per beat, data bytes 0x00..0x1F
        for (int i = 0; i < 32; i++) d[8*i +: 8] = 8'(i);
        run_txn(1'b1, 5, 32'h180, d, 2);

        // Byte write to an odd lane
        run_txn(1'b1, 0, 32'h203, 256'hA5, 0);

        // Half read
        mem[32'h40] = 8'hEF; mem[32'h41] = 8'hBE;
        ref_mem[32'h40] = 8'hEF; ref_mem[32'h41] = 8'hBE;
        run_txn(1'b0, 1, 32'h40, '0, 1);
        check("half_read_value", biu_rdata, 256'hBEEF);

        // Read back the written line
        run_txn(1'b0, 5, 32'h180, '0, 1);

        // Oversized length clamps to a full line
        run_txn(1'b0, 7, 32'h2E0, '0, 0);

        // Reset in the middle of a read
        biu_en = 1'b1; biu_func = 1'b0; biu_len = 3'd5; biu_addr = 32'h300;
        repeat (3) @(negedge clk);
        check("busy_before_reset", wb_cyc, 1'b1);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs",
                 {wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o, biu_done, biu_rdata}, '0);
        @(negedge clk);
        rst = 1'b0;
        biu_en = 1'b0;
        wb_ack = 1'b1;
        @(negedge clk);
        check("ack_ignored_idle", {wb_cyc, biu_done}, 2'b00);
        wb_ack = 1'b0;
        last_rd = '0;

        // Randomized requests
        for (int n = 0; n < 40; n++) begin
            len  = $urandom_range(0, 7);
            size = 1 << ((len > 5) ? 5 : len);
            addr = $urandom_range(0, 1023 - 32) & ~(size - 1);
            for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
            run_txn(1'($urandom_range(0, 1)), len, addr, d, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
